// File: rtl/velocity_settle_detector_pkg.sv
// Shared physics definitions: settle FSM states and default fixed-point sizing
// used by the friction, collision and settle blocks.
package velocity_settle_detector_pkg;

    typedef enum logic [1:0] {
        StMoving   = 2'd0,
        StSettling = 2'd1,
        StAtRest   = 2'd2
    } settle_state_t;

    localparam int unsigned DefaultWidth = 32;
    localparam int unsigned DefaultTol   = 10;

endpackage

// File: rtl/velocity_settle_detector_band_check.sv
// Combinational signed band test: near = (-2^TOL <= v <= 2^TOL), all at WIDTH bits.
module band_check
    import velocity_settle_detector_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned TOL   = DefaultTol
) (
    input  logic signed [WIDTH-1:0] v,
    output logic                    near
);

    // Bounds built at WIDTH bits so the most negative input compares without overflow.
    localparam logic [WIDTH-1:0] PosBits = WIDTH'(1) << TOL;
    localparam logic [WIDTH-1:0] NegBits = (~PosBits) + WIDTH'(1);

    always_comb begin
        near = ($signed(v) >= $signed(NegBits)) && ($signed(v) <= $signed(PosBits));
    end

endmodule

// File: rtl/velocity_settle_detector.sv
// Per-ball settle detector: declares rest after HOLD consecutive near samples and
// clamps velocity to zero until a channel leaves the wider exit band.
module velocity_settle_detector
    import velocity_settle_detector_pkg::*;
#(
    parameter int unsigned WIDTH    = DefaultWidth,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned TOL      = DefaultTol,
    parameter int unsigned EXIT_TOL = 11,
    parameter int unsigned HOLD     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      in_valid,
    input  logic [CHANNELS*WIDTH-1:0] vel,
    output logic                      out_valid,
    output logic [CHANNELS*WIDTH-1:0] vel_out,
    output logic                      at_rest,
    output logic                      settling,
    output logic                      rest_pulse
);

    localparam int unsigned CntW = $clog2(HOLD + 1);

    logic [CHANNELS-1:0] near_entry;
    logic [CHANNELS-1:0] near_exit;
    logic                all_near;
    logic                any_far;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_band
        band_check #(
            .WIDTH (WIDTH),
            .TOL   (TOL)
        ) u_entry (
            .v    (vel[ch*WIDTH +: WIDTH]),
            .near (near_entry[ch])
        );

        band_check #(
            .WIDTH (WIDTH),
            .TOL   (EXIT_TOL)
        ) u_exit (
            .v    (vel[ch*WIDTH +: WIDTH]),
            .near (near_exit[ch])
        );
    end

    assign all_near = &near_entry;
    assign any_far  = ~(&near_exit);

    settle_state_t   state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] cnt_inc;

    assign cnt_inc = cnt_q + CntW'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (in_valid) begin
            case (state_q)
                StMoving: begin
                    if (all_near) begin
                        cnt_d   = CntW'(1);
                        state_d = (HOLD == 1) ? StAtRest : StSettling;
                    end else begin
                        cnt_d = '0;
                    end
                end
                StSettling: begin
                    if (all_near) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CntW'(HOLD)) state_d = StAtRest;
                    end else begin
                        state_d = StMoving;
                        cnt_d   = '0;
                    end
                end
                StAtRest: begin
                    // Samples between the two bands keep the ball at rest.
                    if (any_far) begin
                        state_d = StMoving;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = StMoving;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StMoving;
            cnt_q      <= '0;
            out_valid  <= 1'b0;
            vel_out    <= '0;
            at_rest    <= 1'b0;
            settling   <= 1'b0;
            rest_pulse <= 1'b0;
        end else if (clear) begin
            // The coincident sample is dropped; displayed outputs keep their last values.
            state_q    <= StMoving;
            cnt_q      <= '0;
            out_valid  <= 1'b0;
            rest_pulse <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            out_valid  <= in_valid;
            rest_pulse <= 1'b0;
            if (in_valid) begin
                vel_out    <= (state_d == StAtRest) ? '0 : vel;
                at_rest    <= (state_d == StAtRest);
                settling   <= (state_d == StSettling);
                rest_pulse <= (state_d == StAtRest) && (state_q != StAtRest);
            end
        end
    end

endmodule
